// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and helpers for the serial adder
//
// Purpose : FSM state encoding and the step-counter width helper used by
//           serial_adder.
// Ports   : none (package)

package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a counter that must hold 0 .. n-1; never narrower than 1 bit
    // so a single-step configuration still has a legal vector.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// rtl/serial_adder_digit.sv - combinational DIGIT-bit ripple-carry slice
//
// Purpose : adds two DIGIT-bit digits plus a carry using a chain of
//           full-adder cells.
// Ports   : x, y  - DIGIT-bit addend digits
//           ci    - carry into the least significant cell
//           s     - DIGIT-bit digit sum
//           co    - carry out of the most significant cell

module serial_adder_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        co = c[DIGIT];
    end

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - multi-cycle digit-serial adder with start/ready/done
//
// Purpose : computes {cout,sum} = a + b + cin over WIDTH/DIGIT clock cycles,
//           DIGIT bits per cycle, using one serial_adder_digit slice.
// Option  : SERIAL_ADDER_SUB_EN adds input 'sub'; when set with start the
//           unit computes a - b (cout=1 means no borrow) and ignores cin.
// Ports   : clk    - clock, rising edge
//           rst_n  - asynchronous active-low reset
//           start  - operation request, honoured only while ready
//           a, b   - WIDTH-bit operands, captured with an accepted start
//           cin    - carry-in, captured with an accepted start
//           sub    - (option) subtract select, captured with start
//           ready  - high while idle
//           sum    - registered WIDTH-bit result
//           cout   - registered carry-out
//           done   - one-cycle pulse; sum/cout valid from this cycle

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             done
);

    localparam int NSTEPS = WIDTH / DIGIT;
    localparam int CW     = cnt_width(NSTEPS);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [DIGIT-1:0] slice_s;
    logic             slice_co;
    logic [WIDTH-1:0] psum_shift;
    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             accept;
    logic             last_step;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: a + ~b + 1.
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    assign accept    = (state_q == ST_IDLE) && start;
    assign last_step = (state_q == ST_RUN) && (cnt_q == CW'(NSTEPS - 1));

    serial_adder_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .x  (a_q[DIGIT-1:0]),
        .y  (b_q[DIGIT-1:0]),
        .ci (c_q),
        .s  (slice_s),
        .co (slice_co)
    );

    // New digit enters at the MSB end; after NSTEPS shifts the first digit
    // has reached bit 0. Written as a shifted concatenation so it stays legal
    // when DIGIT == WIDTH.
    assign psum_shift = WIDTH'({slice_s, psum_q} >> DIGIT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)     state_d = ST_RUN;
            ST_RUN:  if (last_step) state_d = ST_DONE;
            ST_DONE:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready = 1'b0;
        done  = 1'b0;
        case (state_q)
            ST_IDLE: ready = 1'b1;
            ST_DONE: done  = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        cnt_d  = cnt_q;
        psum_d = psum_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        if (accept) begin
            a_d   = a;
            b_d   = b_load;
            c_d   = c_load;
            cnt_d = '0;
        end else if (state_q == ST_RUN) begin
            a_d    = a_q >> DIGIT;
            b_d    = b_q >> DIGIT;
            c_d    = slice_co;
            cnt_d  = cnt_q + 1'b1;
            psum_d = psum_shift;
            // Visible result only moves on the final step.
            if (last_step) begin
                sum_d  = psum_shift;
                cout_d = slice_co;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= 1'b0;
            cnt_q  <= '0;
            psum_q <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            c_q    <= c_d;
            cnt_q  <= cnt_d;
            psum_q <= psum_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder

module tb_serial_adder;

    localparam int LIM = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // WIDTH=8, DIGIT=1
    logic       s8_start, s8_cin, s8_ready, s8_cout, s8_done;
    logic [7:0] s8_a, s8_b, s8_sum;
    // WIDTH=8, DIGIT=4
    logic       q_start, q_cin, q_ready, q_cout, q_done;
    logic [7:0] q_a, q_b, q_sum;
    // WIDTH=2, DIGIT=1
    logic       w_start, w_cin, w_ready, w_cout, w_done;
    logic [1:0] w_a, w_b, w_sum;
`ifdef SERIAL_ADDER_SUB_EN
    logic       s8_sub, q_sub, w_sub;
`endif

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8_start), .a(s8_a), .b(s8_b), .cin(s8_cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(s8_sub),
`endif
        .ready(s8_ready), .sum(s8_sum), .cout(s8_cout), .done(s8_done)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut84 (
        .clk(clk), .rst_n(rst_n), .start(q_start), .a(q_a), .b(q_b), .cin(q_cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(q_sub),
`endif
        .ready(q_ready), .sum(q_sum), .cout(q_cout), .done(q_done)
    );

    serial_adder #(.WIDTH(2), .DIGIT(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(w_start), .a(w_a), .b(w_b), .cin(w_cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(w_sub),
`endif
        .ready(w_ready), .sum(w_sum), .cout(w_cout), .done(w_done)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [8:0] exp_q8[$];
    logic [8:0] exp_q4[$];
    logic [2:0] exp_q2[$];

    int done8_cnt = 0;
    always @(negedge clk) if (s8_done === 1'b1) done8_cnt++;

    // Drive one op on the 8/1 unit; returns at the negedge where done is seen.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub, output int lat, output int rdy_low);
        @(negedge clk);
        s8_a = a; s8_b = b; s8_cin = cin; s8_start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        s8_sub = sub;
`endif
        if (sub) exp_q8.push_back({1'b0, a} + {1'b0, ~b} + 9'd1);
        else     exp_q8.push_back({1'b0, a} + {1'b0, b} + {8'd0, cin});
        @(negedge clk);
        s8_start = 1'b0;
        lat = 0; rdy_low = 0;
        while (s8_done !== 1'b1 && lat < LIM) begin
            if (s8_ready === 1'b0) rdy_low++;
            @(negedge clk);
            lat++;
        end
        if (s8_ready === 1'b0) rdy_low++;
        if (lat >= LIM) begin
            tests_run++; tests_failed++;
            $display("FAIL op8_timeout: got no done within %0d cycles", LIM);
        end
    endtask

    task automatic op4(input logic [7:0] a, input logic [7:0] b, input logic cin, output int lat);
        @(negedge clk);
        q_a = a; q_b = b; q_cin = cin; q_start = 1'b1;
        exp_q4.push_back({1'b0, a} + {1'b0, b} + {8'd0, cin});
        @(negedge clk);
        q_start = 1'b0;
        lat = 0;
        while (q_done !== 1'b1 && lat < LIM) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= LIM) begin
            tests_run++; tests_failed++;
            $display("FAIL op4_timeout: got no done within %0d cycles", LIM);
        end
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic cin, output int lat);
        @(negedge clk);
        w_a = a; w_b = b; w_cin = cin; w_start = 1'b1;
        exp_q2.push_back({1'b0, a} + {1'b0, b} + {2'd0, cin});
        @(negedge clk);
        w_start = 1'b0;
        lat = 0;
        while (w_done !== 1'b1 && lat < LIM) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= LIM) begin
            tests_run++; tests_failed++;
            $display("FAIL op2_timeout: got no done within %0d cycles", LIM);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        s8_start = 0; s8_a = 0; s8_b = 0; s8_cin = 0;
        q_start = 0; q_a = 0; q_b = 0; q_cin = 0;
        w_start = 0; w_a = 0; w_b = 0; w_cin = 0;
`ifdef SERIAL_ADDER_SUB_EN
        s8_sub = 0; q_sub = 0; w_sub = 0;
`endif
        repeat (2) @(negedge clk);
        tests_run++;
        if (s8_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", s8_ready); end
        tests_run++;
        if (s8_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", s8_done); end
        tests_run++;
        if ({s8_cout, s8_sum} !== 9'h000) begin tests_failed++; $display("FAIL reset_result: got %h expected 000", {s8_cout, s8_sum}); end
        tests_run++;
        if (q_ready !== 1'b1 || w_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_others: got %b%b expected 11", q_ready, w_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat, rl;
        logic [8:0] e;
        op8(8'h5A, 8'h3C, 1'b0, 1'b0, lat, rl);
        e = exp_q8.pop_front();
        tests_run++;
        if ({s8_cout, s8_sum} !== e) begin tests_failed++; $display("FAIL basic_result: got %h expected %h", {s8_cout, s8_sum}, e); end
        tests_run++;
        if (lat !== 8) begin tests_failed++; $display("FAIL basic_latency: got %0d expected 8", lat); end
        tests_run++;
        if (rl !== 9) begin tests_failed++; $display("FAIL basic_ready_low: got %0d expected 9", rl); end
        @(negedge clk);
        tests_run++;
        if (s8_ready !== 1'b1 || s8_done !== 1'b0) begin tests_failed++; $display("FAIL basic_after: got ready=%b done=%b expected 1 0", s8_ready, s8_done); end
    endtask

    task automatic test_carry;
        int lat, rl;
        logic [8:0] e;
        op8(8'hFF, 8'h01, 1'b0, 1'b0, lat, rl);
        e = exp_q8.pop_front();
        tests_run++;
        if ({s8_cout, s8_sum} !== e) begin tests_failed++; $display("FAIL carry_ff_01: got %h expected %h", {s8_cout, s8_sum}, e); end
        op8(8'hFF, 8'hFF, 1'b1, 1'b0, lat, rl);
        e = exp_q8.pop_front();
        tests_run++;
        if ({s8_cout, s8_sum} !== e) begin tests_failed++; $display("FAIL carry_ff_ff_1: got %h expected %h", {s8_cout, s8_sum}, e); end
    endtask

    task automatic test_ignored_start;
        int lat, d0;
        logic [8:0] e;
        @(negedge clk);
        s8_a = 8'h5A; s8_b = 8'h3C; s8_cin = 1'b0; s8_start = 1'b1;
        exp_q8.push_back(9'h096);
        @(negedge clk);
        s8_start = 1'b0;
        d0 = done8_cnt;
        repeat (3) @(negedge clk);
        s8_a = 8'h00; s8_b = 8'h00; s8_start = 1'b1;
        tests_run++;
        if ({s8_cout, s8_sum} !== 9'h1FF) begin tests_failed++; $display("FAIL ign_held: got %h expected 1ff", {s8_cout, s8_sum}); end
        @(negedge clk);
        s8_start = 1'b0;
        lat = 0;
        while (s8_done !== 1'b1 && lat < LIM) begin @(negedge clk); lat++; end
        e = exp_q8.pop_front();
        tests_run++;
        if ({s8_cout, s8_sum} !== e) begin tests_failed++; $display("FAIL ign_result: got %h expected %h", {s8_cout, s8_sum}, e); end
        repeat (12) @(negedge clk);
        tests_run++;
        if (done8_cnt - d0 !== 1) begin tests_failed++; $display("FAIL ign_done_count: got %0d expected 1", done8_cnt - d0); end
        tests_run++;
        if (s8_ready !== 1'b1 || {s8_cout, s8_sum} !== 9'h096) begin tests_failed++; $display("FAIL ign_after: got ready=%b res=%h expected 1 096", s8_ready, {s8_cout, s8_sum}); end
    endtask

    task automatic test_reset_mid;
        int lat, rl, d0;
        logic [8:0] e;
        @(negedge clk);
        s8_a = 8'h5A; s8_b = 8'h3C; s8_cin = 1'b0; s8_start = 1'b1;
        @(negedge clk);
        s8_start = 1'b0;
        repeat (4) @(negedge clk);
        d0 = done8_cnt;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({s8_cout, s8_sum} !== 9'h000) begin tests_failed++; $display("FAIL rmid_result: got %h expected 000", {s8_cout, s8_sum}); end
        tests_run++;
        if (s8_ready !== 1'b1 || s8_done !== 1'b0) begin tests_failed++; $display("FAIL rmid_flags: got ready=%b done=%b expected 1 0", s8_ready, s8_done); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        tests_run++;
        if (done8_cnt !== d0) begin tests_failed++; $display("FAIL rmid_no_done: got %0d pulses expected 0", done8_cnt - d0); end
        op8(8'h01, 8'h02, 1'b0, 1'b0, lat, rl);
        e = exp_q8.pop_front();
        tests_run++;
        if ({s8_cout, s8_sum} !== e) begin tests_failed++; $display("FAIL rmid_next: got %h expected %h", {s8_cout, s8_sum}, e); end
    endtask

    task automatic test_back_to_back;
        int n;
        @(negedge clk);
        s8_a = 8'h10; s8_b = 8'h20; s8_cin = 1'b0; s8_start = 1'b1;
        @(negedge clk);
        s8_a = 8'h33; s8_b = 8'h44; s8_cin = 1'b1;
        n = 0;
        while (s8_done !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
        tests_run++;
        if ({s8_cout, s8_sum} !== 9'h030) begin tests_failed++; $display("FAIL b2b_first: got %h expected 030", {s8_cout, s8_sum}); end
        n = 0;
        @(negedge clk); n++;
        tests_run++;
        if (s8_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_idle: got ready=%b expected 1", s8_ready); end
        @(negedge clk); n++;
        s8_start = 1'b0;
        while (s8_done !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
        tests_run++;
        if (n !== 10) begin tests_failed++; $display("FAIL b2b_interval: got %0d expected 10", n); end
        tests_run++;
        if ({s8_cout, s8_sum} !== 9'h078) begin tests_failed++; $display("FAIL b2b_second: got %h expected 078", {s8_cout, s8_sum}); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random8;
        int lat, rl;
        logic [8:0] e;
        logic [7:0] ra, rb;
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            op8(ra, rb, 1'($urandom), 1'b0, lat, rl);
            e = exp_q8.pop_front();
            tests_run++;
            if ({s8_cout, s8_sum} !== e || lat !== 8) begin
                tests_failed++;
                $display("FAIL rand8_%0d: got %h lat %0d expected %h lat 8", i, {s8_cout, s8_sum}, lat, e);
            end
        end
    endtask

    task automatic test_w2_exhaustive;
        int lat;
        logic [2:0] e;
        for (int k = 0; k < 32; k++) begin
            op2(2'(k >> 3), 2'(k >> 1), 1'(k), lat);
            e = exp_q2.pop_front();
            tests_run++;
            if ({w_cout, w_sum} !== e || lat !== 2) begin
                tests_failed++;
                $display("FAIL w2_%0d: got %h lat %0d expected %h lat 2", k, {w_cout, w_sum}, lat, e);
            end
        end
    endtask

    task automatic test_d4_random;
        int lat;
        logic [8:0] e;
        logic [7:0] ra, rb;
        for (int i = 0; i < 30; i++) begin
            ra = (i == 0) ? 8'hFF : 8'($urandom);
            rb = (i == 0) ? 8'hFF : 8'($urandom);
            op4(ra, rb, (i == 0) ? 1'b1 : 1'($urandom), lat);
            e = exp_q4.pop_front();
            tests_run++;
            if ({q_cout, q_sum} !== e || lat !== 2) begin
                tests_failed++;
                $display("FAIL d4_%0d: got %h lat %0d expected %h lat 2", i, {q_cout, q_sum}, lat, e);
            end
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        int lat, rl;
        logic [8:0] e;
        op8(8'h05, 8'h07, 1'b0, 1'b1, lat, rl);
        e = exp_q8.pop_front();
        tests_run++;
        if ({s8_cout, s8_sum} !== e) begin tests_failed++; $display("FAIL sub_5_7: got %h expected %h", {s8_cout, s8_sum}, e); end
        op8(8'h07, 8'h05, 1'b0, 1'b1, lat, rl);
        e = exp_q8.pop_front();
        tests_run++;
        if ({s8_cout, s8_sum} !== e) begin tests_failed++; $display("FAIL sub_7_5: got %h expected %h", {s8_cout, s8_sum}, e); end
        s8_sub = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_carry;
        test_ignored_start;
        test_reset_mid;
        test_back_to_back;
        test_random8;
        test_w2_exhaustive;
        test_d4_random;
`ifdef SERIAL_ADDER_SUB_EN
        test_sub;
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
